// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared definitions for the NPC writeback/commit slice.
//               Commit-controller state encoding (2 bits) and the default
//               reset PC and counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
    localparam int          C_CNT_W    = 64;

endpackage
`default_nettype wire

// File: rtl/wb_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wb_perf_cnt
// Description : CNT_W-wide free-wrapping counter with enable and synchronous
//               clear.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               i_clr     - synchronous clear (same effect as rst)
//               i_en      - count enable
//               o_count   - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module wb_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_ctrl
// Description : Fetch/commit sequencer of the multi-cycle NPC. Owns the PC,
//               issues one fetch at a time, accepts the writeback bundle,
//               commits it in one cycle and halts on ebreak or a misaligned
//               next PC.
// Ports       : clk, rst                 - clock, sync active-high reset
//               fetch_valid/ready/pc     - IFU request handshake
//               wb_valid/ready, wb_*     - writeback bundle handshake
//               gpr_*/csr_*              - gated architectural write ports
//               halt, halt_misalign      - halt status and cause
//               retire_cnt               - committed instruction count
//               perf_cycle_cnt/wait_cnt  - optional performance counters
// Config      : WB_PERF_CNT_EN - when defined, builds the perf counters;
//               otherwise the perf ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_ctrl
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter int          CNT_W    = C_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [31:0]      fetch_pc,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [31:0]      wb_dnpc,
    input  logic             wb_gpr_wen,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_gpr_wdata,
    input  logic             wb_csr_wen,
    input  logic [11:0]      wb_csr_addr,
    input  logic [31:0]      wb_csr_wdata,
    input  logic             wb_is_ebreak,
    output logic             gpr_wen,
    output logic [4:0]       gpr_waddr,
    output logic [31:0]      gpr_wdata,
    output logic             csr_wen,
    output logic [11:0]      csr_waddr,
    output logic [31:0]      csr_wdata,
    output logic             halt,
    output logic             halt_misalign,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] perf_cycle_cnt,
    output logic [CNT_W-1:0] perf_wait_cnt
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_halt_misalign;

    // Latched writeback bundle
    logic [31:0] r_dnpc;
    logic        r_gpr_wen;
    logic [4:0]  r_rd;
    logic [31:0] r_gpr_wdata;
    logic        r_csr_wen;
    logic [11:0] r_csr_addr;
    logic [31:0] r_csr_wdata;
    logic        r_is_ebreak;

    logic        w_accept;
    logic        w_misalign;
    logic        w_commit_ok;

    assign w_accept    = (r_state == ST_WAIT) && wb_valid;
    assign w_misalign  = (r_dnpc[1:0] != 2'b00);
    // A commit with a misaligned target retires nothing and writes nothing.
    assign w_commit_ok = (r_state == ST_COMMIT) && !w_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fetch_valid = 1'b0;
        wb_ready    = 1'b0;
        gpr_wen     = 1'b0;
        csr_wen     = 1'b0;
        halt        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                fetch_valid = 1'b1;
                if (fetch_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (w_misalign) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    gpr_wen     = r_gpr_wen && (r_rd != 5'd0);
                    csr_wen     = r_csr_wen;
                    w_state_nxt = r_is_ebreak ? ST_HALT : ST_FETCH;
                end
            end
            default: begin
                halt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dnpc      <= '0;
            r_gpr_wen   <= 1'b0;
            r_rd        <= '0;
            r_gpr_wdata <= '0;
            r_csr_wen   <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_is_ebreak <= 1'b0;
        end else if (w_accept) begin
            r_dnpc      <= wb_dnpc;
            r_gpr_wen   <= wb_gpr_wen;
            r_rd        <= wb_rd;
            r_gpr_wdata <= wb_gpr_wdata;
            r_csr_wen   <= wb_csr_wen;
            r_csr_addr  <= wb_csr_addr;
            r_csr_wdata <= wb_csr_wdata;
            r_is_ebreak <= wb_is_ebreak;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_halt_misalign <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            if (w_misalign) begin
                r_halt_misalign <= 1'b1;
            end else begin
                r_pc <= r_dnpc;
            end
        end
    end

    assign fetch_pc      = r_pc;
    assign gpr_waddr     = r_rd;
    assign gpr_wdata     = r_gpr_wdata;
    assign csr_waddr     = r_csr_addr;
    assign csr_wdata     = r_csr_wdata;
    assign halt_misalign = r_halt_misalign;

    wb_perf_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_en    (w_commit_ok),
        .o_count (retire_cnt)
    );

`ifdef WB_PERF_CNT_EN
    wb_perf_cnt #(.CNT_W(CNT_W)) u_perf_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_en    (r_state != ST_HALT),
        .o_count (perf_cycle_cnt)
    );

    wb_perf_cnt #(.CNT_W(CNT_W)) u_perf_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_en    ((r_state == ST_WAIT) && !wb_valid),
        .o_count (perf_wait_cnt)
    );
`else
    assign perf_cycle_cnt = '0;
    assign perf_wait_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_commit_ctrl
// Description : Self-checking bench for wb_commit_ctrl. Drives directed and
//               randomized instructions and compares against an
//               architectural-level model (pc, retire count, halt status).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_commit_ctrl;

    localparam logic [31:0] c_reset_pc = 32'h8000_0000;
    localparam int          c_cnt_w    = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fetch_valid;
    logic               fetch_ready = 1'b0;
    logic [31:0]        fetch_pc;
    logic               wb_valid = 1'b0;
    logic               wb_ready;
    logic [31:0]        wb_dnpc = '0;
    logic               wb_gpr_wen = 1'b0;
    logic [4:0]         wb_rd = '0;
    logic [31:0]        wb_gpr_wdata = '0;
    logic               wb_csr_wen = 1'b0;
    logic [11:0]        wb_csr_addr = '0;
    logic [31:0]        wb_csr_wdata = '0;
    logic               wb_is_ebreak = 1'b0;
    logic               gpr_wen;
    logic [4:0]         gpr_waddr;
    logic [31:0]        gpr_wdata;
    logic               csr_wen;
    logic [11:0]        csr_waddr;
    logic [31:0]        csr_wdata;
    logic               halt;
    logic               halt_misalign;
    logic [c_cnt_w-1:0] retire_cnt;
    logic [c_cnt_w-1:0] perf_cycle_cnt;
    logic [c_cnt_w-1:0] perf_wait_cnt;

    always #5 clk = ~clk;

    wb_commit_ctrl #(.RESET_PC(c_reset_pc), .CNT_W(c_cnt_w)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_dnpc        (wb_dnpc),
        .wb_gpr_wen     (wb_gpr_wen),
        .wb_rd          (wb_rd),
        .wb_gpr_wdata   (wb_gpr_wdata),
        .wb_csr_wen     (wb_csr_wen),
        .wb_csr_addr    (wb_csr_addr),
        .wb_csr_wdata   (wb_csr_wdata),
        .wb_is_ebreak   (wb_is_ebreak),
        .gpr_wen        (gpr_wen),
        .gpr_waddr      (gpr_waddr),
        .gpr_wdata      (gpr_wdata),
        .csr_wen        (csr_wen),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .halt           (halt),
        .halt_misalign  (halt_misalign),
        .retire_cnt     (retire_cnt),
        .perf_cycle_cnt (perf_cycle_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
    );

    // Architectural reference model
    logic [31:0] m_pc;
    longint      m_retired;
    longint      m_wait;
    bit          m_halted;
    bit          m_misalign;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_wb();
        wb_dnpc      = $urandom;
        wb_gpr_wen   = 1'($urandom);
        wb_rd        = 5'($urandom);
        wb_gpr_wdata = $urandom;
        wb_csr_wen   = 1'($urandom);
        wb_csr_addr  = 12'($urandom);
        wb_csr_wdata = $urandom;
        wb_is_ebreak = 1'($urandom);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        fetch_ready = 1'b0;
        wb_valid    = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        m_pc       = c_reset_pc;
        m_retired  = 0;
        m_wait     = 0;
        m_halted   = 1'b0;
        m_misalign = 1'b0;
        check("rst_fetch_valid", 64'(fetch_valid), 64'd1);
        check("rst_wb_ready", 64'(wb_ready), 64'd0);
        check("rst_wen", 64'({gpr_wen, csr_wen}), 64'd0);
        check("rst_pc", 64'(fetch_pc), 64'(c_reset_pc));
        check("rst_retire", retire_cnt, 64'd0);
        check("rst_halt", 64'({halt, halt_misalign}), 64'd0);
`ifdef WB_PERF_CNT_EN
        check("rst_perf", perf_cycle_cnt | perf_wait_cnt, 64'd0);
`else
        check("perf_tied", perf_cycle_cnt | perf_wait_cnt, 64'd0);
`endif
    endtask

    // Runs one instruction from FETCH through COMMIT; entered and left at a negedge.
    task automatic do_instr(input logic [31:0] dnpc, input bit gwen, input logic [4:0] rd,
                            input logic [31:0] gdata, input bit cwen, input logic [11:0] caddr,
                            input logic [31:0] cdata, input bit ebrk, input int fdly, input int wdly);
        bit mis;
        bit exp_gwen;
        check("fetch_valid", 64'(fetch_valid), 64'd1);
        check("fetch_pc", 64'(fetch_pc), 64'(m_pc));
        for (int i = 0; i < fdly; i++) begin
            fetch_ready = 1'b0;
            @(negedge clk);
            check("stall_pc", 64'({fetch_valid, fetch_pc}), {31'd0, 1'b1, m_pc});
        end
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        check("wait_handshake", 64'({fetch_valid, wb_ready}), 64'b01);
        for (int i = 0; i < wdly; i++) begin
            wb_valid = 1'b0;
            @(negedge clk);
            m_wait++;
        end
        wb_valid = 1'b1;
        wb_dnpc = dnpc; wb_gpr_wen = gwen; wb_rd = rd; wb_gpr_wdata = gdata;
        wb_csr_wen = cwen; wb_csr_addr = caddr; wb_csr_wdata = cdata; wb_is_ebreak = ebrk;
        @(negedge clk);
        wb_valid = 1'b0;
        scramble_wb();
        // model: commit cycle
        mis      = (dnpc[1:0] != 2'b00);
        exp_gwen = !mis && gwen && (rd != 5'd0);
        check("commit_gpr_wen", 64'(gpr_wen), 64'(exp_gwen));
        if (exp_gwen) check("commit_gpr", 64'({gpr_waddr, gpr_wdata}), {27'd0, rd, gdata});
        check("commit_csr_wen", 64'(csr_wen), 64'(!mis && cwen));
        if (!mis && cwen) check("commit_csr", 64'({csr_waddr, csr_wdata}), {20'd0, caddr, cdata});
        check("commit_no_fetch", 64'({fetch_valid, wb_ready}), 64'd0);
`ifdef WB_PERF_CNT_EN
        check("perf_wait", perf_wait_cnt, 64'(m_wait));
`endif
        if (!mis) begin
            m_retired++;
            m_pc = dnpc;
        end
        m_halted   = mis || ebrk;
        m_misalign = mis;
        @(negedge clk);
        check("retire_cnt", retire_cnt, 64'(m_retired));
        check("halt", 64'({halt, halt_misalign}), 64'({m_halted, m_misalign}));
        check("post_fetch_valid", 64'(fetch_valid), 64'(!m_halted));
        check("post_wen", 64'({gpr_wen, csr_wen}), 64'd0);
        if (!m_halted) check("post_pc", 64'(fetch_pc), 64'(m_pc));
    endtask

    task automatic hold_halt(input int cycles);
        int     bad;
        longint r0;
        bad = 0;
        r0  = longint'(retire_cnt);
        for (int i = 0; i < cycles; i++) begin
            fetch_ready = 1'($urandom);
            wb_valid    = 1'($urandom);
            scramble_wb();
            @(negedge clk);
            if (fetch_valid || wb_ready || gpr_wen || csr_wen || !halt || halt_misalign !== m_misalign)
                bad++;
        end
        fetch_ready = 1'b0;
        wb_valid    = 1'b0;
        check("halt_hold_bad", 64'(bad), 64'd0);
        check("halt_retire_frozen", retire_cnt, 64'(r0));
    endtask

    initial begin
        @(negedge clk);
        // single instruction
        do_reset();
        do_instr(32'h8000_0004, 1, 5'd5, 32'hDEAD_BEEF, 0, 12'h0, 32'h0, 0, 0, 0);
        // x0 write is suppressed but still retires
        do_instr(32'h8000_0008, 1, 5'd0, 32'h1234_5678, 0, 12'h0, 32'h0, 0, 1, 2);
        // CSR write with redirect
        do_instr(32'h8000_1000, 0, 5'd3, 32'h0, 1, 12'h341, 32'h8000_0010, 0, 0, 1);
        // randomized aligned instructions
        for (int k = 0; k < 40; k++) begin
            do_instr($urandom & 32'hFFFF_FFFC, 1'($urandom), 5'($urandom), $urandom,
                     1'($urandom), 12'($urandom), $urandom, 0,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        // ebreak commits its write, then halts
        do_instr(32'h8000_2000, 1, 5'd10, 32'hCAFE_F00D, 0, 12'h0, 32'h0, 1, 0, 0);
        hold_halt(20);
        // misaligned next PC
        do_reset();
        do_instr(32'h8000_0002, 1, 5'd7, 32'h5555_AAAA, 1, 12'h300, 32'h1, 0, 0, 0);
        check("misalign_pc_kept", 64'(fetch_pc), 64'(c_reset_pc));
        hold_halt(5);
        // backpressure, then reset while in WAIT
        do_reset();
        do_instr(32'h8000_0040, 1, 5'd1, 32'h0000_0001, 0, 12'h0, 32'h0, 0, 5, 7);
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        check("wait_before_rst", 64'(wb_ready), 64'd1);
        wb_valid = 1'b1; wb_dnpc = 32'h8000_0100; wb_gpr_wen = 1'b1; wb_rd = 5'd9;
        wb_csr_wen = 1'b1; wb_is_ebreak = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        wb_valid = 1'b0;
        check("midrst_pc", 64'(fetch_pc), 64'(c_reset_pc));
        check("midrst_retire", retire_cnt, 64'd0);
        check("midrst_fetch_valid", 64'({fetch_valid, wb_ready}), 64'b10);
        check("midrst_wen", 64'({gpr_wen, csr_wen}), 64'd0);
        @(negedge clk);
        check("midrst_no_commit", 64'({gpr_wen, csr_wen, fetch_valid}), 64'b001);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_commit_ctrl.md
Name: wb_commit_ctrl

Overview:
- Sequencer between the writeback datapath and architectural state in the multi-cycle NPC.
- Owns the PC register and issues one fetch request at a time to IFU.
- Accepts the finished writeback bundle (dnpc, GPR/CSR write intents) from LSU/WBU over a valid/ready handshake, then commits it in a single cycle.
- Gates all GPR/CSR write enables, counts retired instructions, and halts on ebreak or a misaligned next PC.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- CNT_W, 64, width of retire and perf counters.

Ports:
- clk  in  1  system clock; only clock.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  out  1  request IFU to fetch at fetch_pc.
- fetch_ready  in  1  IFU accepts request.
- fetch_pc  out  32  current PC.
- wb_valid  in  1  writeback bundle valid.
- wb_ready  out  1  controller can accept bundle.
- wb_dnpc  in  32  next PC computed by WBU.
- wb_gpr_wen  in  1  instruction writes GPR.
- wb_rd  in  5  destination GPR.
- wb_gpr_wdata  in  32  GPR write data.
- wb_csr_wen  in  1  instruction writes CSR.
- wb_csr_addr  in  12  CSR address.
- wb_csr_wdata  in  32  CSR write data.
- wb_is_ebreak  in  1  instruction is ebreak.
- gpr_wen  out  1  register-file write strobe.
- gpr_waddr  out  5  register-file write address.
- gpr_wdata  out  32  register-file write data.
- csr_wen  out  1  CSR-file write strobe.
- csr_waddr  out  12  CSR write address.
- csr_wdata  out  32  CSR write data.
- halt  out  1  core halted.
- halt_misalign  out  1  halt cause: dnpc[1:0] != 0.
- retire_cnt  out  CNT_W  instructions committed.
- perf_cycle_cnt  out  CNT_W  cycles since reset (optional feature).
- perf_wait_cnt  out  CNT_W  cycles waiting for writeback (optional feature).

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high, sampled on the rising clk edge.
- Reset state: state=FETCH, pc=RESET_PC, retire_cnt=0, halt=0, halt_misalign=0, latched bundle cleared.
- Reset values of outputs in the first cycle after reset: fetch_valid=1, wb_ready=0, gpr_wen=0, csr_wen=0.
- rst asserted in any state, mid-transaction included: the next cycle is the reset state. Any latched bundle is discarded with no write.
- FETCH state:
  - fetch_valid=1, fetch_pc=pc.
  - When fetch_ready=1, go to WAIT. fetch_valid deasserts the next cycle.
  - fetch_valid stays high, with fetch_pc stable, until accepted.
- WAIT state:
  - wb_ready=1.
  - When wb_valid=1, latch every wb_* field and go to COMMIT.
  - wb_valid while not in WAIT is ignored; the upstream stage must hold it.
- COMMIT state (exactly one cycle), all outputs driven from latched values:
  - gpr_wen = latched gpr_wen AND rd != 0. Writes to x0 are suppressed.
  - csr_wen = latched csr_wen.
  - retire_cnt increments; it wraps at 2^CNT_W.
  - If latched dnpc[1:0] != 0:
    - gpr_wen=0, csr_wen=0, retire_cnt does not increment, pc unchanged.
    - Next state HALT with halt_misalign=1.
  - Else if ebreak: writes commit, pc<=dnpc, next state HALT.
  - Else: pc<=dnpc, next state FETCH.
- HALT state: halt=1; fetch_valid=0, wb_ready=0, write enables 0. Left only by rst.
- Latency:
  - Bundle accepted at edge N.
  - Write strobes are high during cycle N+1.
  - New fetch_valid with the updated pc in cycle N+2.
  - Minimum 3 cycles per instruction excluding IFU/IDU/EXU/LSU time.
- Write enables are never high outside COMMIT. At most one commit per instruction.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined:
  - perf_cycle_cnt increments every cycle not in HALT.
  - perf_wait_cnt increments each WAIT cycle with wb_valid=0.
  - Both reset to 0 and wrap.
- Undefined: both ports tied to 0 and no counter flops are synthesized. All other behaviour is identical.

Decomposition:
- Shared package (npc_pkg): state encoding FETCH/WAIT/COMMIT/HALT (2 bits), RESET_PC default, CNT_W default.
- Sub-module wb_perf_cnt: a CNT_W-wide enable/clear counter. It is instantiated for retire_cnt and, under WB_PERF_CNT_EN, for both perf counters.

Test Plan:
- Reset then single instruction:
  - Stimulus: after reset, fetch_ready=1; then wb_valid with dnpc=0x80000004, rd=5, wdata=0xDEADBEEF, gpr_wen=1.
  - Required: fetch_pc=0x80000000; gpr_wen pulses one cycle with waddr=5; next fetch_pc=0x80000004; retire_cnt=1.
- x0 write:
  - Stimulus: bundle with rd=0, gpr_wen=1.
  - Required: gpr_wen stays 0; retire_cnt still increments; pc advances.
- CSR plus ecall-style redirect:
  - Stimulus: csr_wen=1, addr=0x341, wdata=0x80000010, dnpc=0x80001000.
  - Required: csr_wen one cycle with those values; fetch_pc=0x80001000.
- ebreak:
  - Stimulus: wb_is_ebreak=1 with rd=10 write.
  - Required: GPR write commits; halt=1 the next cycle; halt_misalign=0; fetch_valid stays 0 for 20 cycles.
- Misaligned dnpc:
  - Stimulus: dnpc=0x80000002 with gpr_wen=1.
  - Required: no write; retire_cnt unchanged; halt=1 and halt_misalign=1.
- Backpressure and reset mid-operation:
  - Stimulus: fetch_ready low for 5 cycles, then wb_valid late by 7 cycles; then rst asserted while in WAIT.
  - Required: fetch_pc stable while stalled; perf_wait_cnt=7 (WB_PERF_CNT_EN defined); the cycle after rst, pc=RESET_PC, retire_cnt=0, fetch_valid=1.
